// File: rtl/boot_loader_if.sv
// Boot-port bundle between the UART byte stream, the loader and the CPU boot inputs.
// The master side feeds received bytes; the slave side (the loader) drives the CPU boot port.
interface boot_loader_if #(
  parameter int BITS  = 32,
  parameter int ADDRW = 14
);
  logic [7:0]      rx_data;
  logic            rx_rdy;
  logic [BITS-1:0] wdata_data;
  logic [ADDRW:0]  wdata_addr;
  logic [2:0]      dst;
  logic            bootloading;
  logic            boot_err;

  modport master (
    output rx_data, rx_rdy,
    input  wdata_data, wdata_addr, dst, bootloading, boot_err
  );

  modport slave (
    input  rx_data, rx_rdy,
    output wdata_data, wdata_addr, dst, bootloading, boot_err
  );
endinterface

// File: rtl/boot_loader.sv
// Serial program loader: parses a UART byte stream into IMEM/DMEM word writes
// and holds the CPU in boot until the END command arrives.
module boot_loader #(
  parameter int BITS  = 32,
  parameter int ADDRW = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  boot_loader_if.slave bus
);

  typedef enum logic [2:0] {
    ST_CMD,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_DATA,
    ST_DONE
  } state_t;

  localparam logic [7:0] CMD_IMEM = 8'h01;
  localparam logic [7:0] CMD_DMEM = 8'h02;
  localparam logic [7:0] CMD_END  = 8'hFF;

  state_t          state_p0;
  logic            sel_imem_p0;
  logic [15:0]     cnt_p0;
  logic [ADDRW:0]  addr_p0;
  logic [1:0]      idx_p0;
  logic [BITS-1:0] word_p0;
  logic            bootloading_p0;
  logic            boot_err_p0;

  logic            vld_p1;
  logic [2:0]      dst_p1;
  logic [BITS-1:0] wdata_p1;
  logic [ADDRW:0]  waddr_p1;

  logic            strobe;
  logic            word_done;
  logic [BITS-1:0] word_full;

  function automatic logic [BITS-1:0] put_lane(input logic [BITS-1:0] w,
                                               input logic [1:0]      idx,
                                               input logic [7:0]      b);
    logic [BITS-1:0] r;
    r = w;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

  assign strobe    = bus.rx_rdy;
  assign word_done = strobe && (state_p0 == ST_DATA) && (idx_p0 == 2'd3);
  assign word_full = put_lane(word_p0, idx_p0, bus.rx_data);

  // stage p0: command parser, byte counter and section bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0       <= ST_CMD;
      sel_imem_p0    <= 1'b0;
      cnt_p0         <= 16'd0;
      addr_p0        <= '0;
      idx_p0         <= 2'd0;
      bootloading_p0 <= 1'b1;
      boot_err_p0    <= 1'b0;
    end else if (strobe) begin
      case (state_p0)
        ST_CMD: begin
          if (bus.rx_data == CMD_IMEM || bus.rx_data == CMD_DMEM) begin
            sel_imem_p0 <= (bus.rx_data == CMD_IMEM);
            addr_p0     <= '0;
            state_p0    <= ST_CNT_LO;
          end else if (bus.rx_data == CMD_END) begin
            bootloading_p0 <= 1'b0;
            state_p0       <= ST_DONE;
          end else begin
            boot_err_p0 <= 1'b1;
          end
        end
        ST_CNT_LO: begin
          cnt_p0[7:0] <= bus.rx_data;
          state_p0    <= ST_CNT_HI;
        end
        ST_CNT_HI: begin
          cnt_p0[15:8] <= bus.rx_data;
          idx_p0       <= 2'd0;
          state_p0     <= ({bus.rx_data, cnt_p0[7:0]} == 16'd0) ? ST_CMD : ST_DATA;
        end
        ST_DATA: begin
          idx_p0 <= idx_p0 + 2'd1;
          if (idx_p0 == 2'd3) begin
            addr_p0 <= addr_p0 + 1'b1;
            cnt_p0  <= cnt_p0 - 16'd1;
            if (cnt_p0 == 16'd1) state_p0 <= ST_CMD;
          end
        end
        ST_DONE: state_p0 <= ST_DONE;
        default: state_p0 <= ST_CMD;
      endcase
    end
  end

  // Assembly register carries no control meaning; stale lanes are always overwritten.
  always_ff @(posedge clk) begin
    if (strobe && state_p0 == ST_DATA) word_p0 <= word_full;
  end

  // stage p1: registered write pulse, decoupled from the parser so the next byte is never lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      dst_p1   <= 3'b000;
      wdata_p1 <= '0;
      waddr_p1 <= '0;
    end else begin
      vld_p1 <= word_done;
      if (word_done) begin
        dst_p1   <= {sel_imem_p0, ~sel_imem_p0, 1'b0};
        wdata_p1 <= word_full;
        waddr_p1 <= addr_p0;
      end else begin
        dst_p1 <= 3'b000;
      end
    end
  end

  assign bus.dst         = vld_p1 ? dst_p1 : 3'b000;
  assign bus.wdata_data  = wdata_p1;
  assign bus.wdata_addr  = waddr_p1;
  assign bus.bootloading = bootloading_p0;
  assign bus.boot_err    = boot_err_p0;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: byte streams are parsed by a section-level reference model
// and every write pulse, its cycle, boot_err and the boot release cycle are compared.
module tb_boot_loader;
  localparam int BITS  = 32;
  localparam int ADDRW = 3;

  typedef struct packed {
    int             cyc;
    logic [2:0]     dst;
    logic [ADDRW:0] addr;
    logic [31:0]    data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  boot_loader_if #(.BITS(BITS), .ADDRW(ADDRW)) bus ();
  boot_loader #(.BITS(BITS), .ADDRW(ADDRW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] s_q[$];
  int         e_q[$];
  wr_t        act_wr[$];
  wr_t        exp_wr[$];
  int         act_drop = -1;
  int         exp_drop = -1;
  logic       exp_err = 1'b0;

  always @(negedge clk) begin
    if (bus.dst !== 3'b000) act_wr.push_back('{cyc, bus.dst, bus.wdata_addr, bus.wdata_data});
    if (bus.bootloading === 1'b0 && act_drop < 0) act_drop = cyc;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.rx_rdy = 1'b0;
    bus.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    act_wr.delete();
    e_q.delete();
    act_drop = -1;
  endtask

  task automatic drive(input int max_gap, input int tail);
    foreach (s_q[i]) begin
      repeat ($urandom_range(max_gap, 0)) @(negedge clk);
      bus.rx_data = s_q[i];
      bus.rx_rdy = 1'b1;
      e_q.push_back(cyc + 1);
      @(negedge clk);
      bus.rx_rdy = 1'b0;
      bus.rx_data = 8'($urandom);
    end
    repeat (tail) @(negedge clk);
  endtask

  // Section-level parse of the whole stream: command, count, then whole words.
  task automatic model_run();
    int  i;
    int  n;
    int  base;
    logic [7:0] c;
    exp_wr.delete();
    exp_err = 1'b0;
    exp_drop = -1;
    i = 0;
    while (i < s_q.size()) begin
      c = s_q[i];
      if (c == 8'h01 || c == 8'h02) begin
        if (i + 2 >= s_q.size()) break;
        n = int'({s_q[i+2], s_q[i+1]});
        for (int w = 0; w < n; w++) begin
          base = i + 3 + 4 * w;
          if (base + 3 >= s_q.size()) break;
          exp_wr.push_back('{e_q[base+3], (c == 8'h01) ? 3'b100 : 3'b010,
                             (ADDRW+1)'(w % (1 << (ADDRW + 1))),
                             {s_q[base+3], s_q[base+2], s_q[base+1], s_q[base]}});
        end
        i = i + 3 + 4 * n;
      end else if (c == 8'hFF) begin
        exp_drop = e_q[i];
        break;
      end else begin
        exp_err = 1'b1;
        i++;
      end
    end
  endtask

  task automatic gen_stream(input int max_words);
    logic [7:0] j;
    int n;
    s_q.delete();
    repeat ($urandom_range(3, 1)) begin
      if ($urandom_range(3, 0) == 0) begin
        do j = 8'($urandom); while (j == 8'h01 || j == 8'h02 || j == 8'hFF);
        s_q.push_back(j);
      end
      n = $urandom_range(max_words, 0);
      s_q.push_back(($urandom_range(1, 0) == 1) ? 8'h01 : 8'h02);
      s_q.push_back(8'(n));
      s_q.push_back(8'(n >> 8));
      repeat (4 * n) s_q.push_back(8'($urandom));
    end
    s_q.push_back(8'hFF);
    s_q.push_back(8'h01);
    s_q.push_back(8'h01);
    s_q.push_back(8'h00);
    repeat (4) s_q.push_back(8'($urandom));
  endtask

  task automatic test_reset();
    int bad = 0;
    do_reset();
    repeat (100) begin
      @(negedge clk);
      if (bus.bootloading !== 1'b1 || bus.dst !== 3'b000) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_idle bad_cycles %0d want 0", bad); end
    checks++;
    if (bus.wdata_data !== 32'h0 || bus.wdata_addr !== '0 || bus.boot_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals data %h addr %h err %b want 0 0 0", bus.wdata_data, bus.wdata_addr, bus.boot_err);
    end
  endtask

  task automatic test_imem_two_words();
    string nm = "imem2";
    do_reset();
    s_q = '{8'h01, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
    drive(2, 8);
    model_run();
    checks++;
    if (act_wr.size() != exp_wr.size()) begin errors++; $display("FAIL %s count got %0d want %0d", nm, act_wr.size(), exp_wr.size()); end
    for (int k = 0; k < exp_wr.size() && k < act_wr.size(); k++) begin
      checks++;
      if (act_wr[k] !== exp_wr[k]) begin errors++; $display("FAIL %s wr%0d got %h want %h", nm, k, act_wr[k], exp_wr[k]); end
    end
    checks++;
    if (act_wr.size() == 2 && act_wr[1].data !== 32'h12345678) begin errors++; $display("FAIL %s word1 got %h want 12345678", nm, act_wr[1].data); end
    checks++;
    if (bus.wdata_data !== 32'h12345678 || bus.wdata_addr !== 4'd1) begin
      errors++; $display("FAIL %s hold got %h@%0d want 12345678@1", nm, bus.wdata_data, bus.wdata_addr);
    end
    checks++;
    if (bus.bootloading !== 1'b1) begin errors++; $display("FAIL %s bootloading got %b want 1", nm, bus.bootloading); end
  endtask

  task automatic test_dmem_end();
    string nm = "dmem_end";
    do_reset();
    s_q = '{8'h02, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hFF};
    drive(2, 8);
    model_run();
    checks++;
    if (act_wr.size() != exp_wr.size()) begin errors++; $display("FAIL %s count got %0d want %0d", nm, act_wr.size(), exp_wr.size()); end
    for (int k = 0; k < exp_wr.size() && k < act_wr.size(); k++) begin
      checks++;
      if (act_wr[k] !== exp_wr[k]) begin errors++; $display("FAIL %s wr%0d got %h want %h", nm, k, act_wr[k], exp_wr[k]); end
    end
    checks++;
    if (act_drop != exp_drop) begin errors++; $display("FAIL %s boot_drop got %0d want %0d", nm, act_drop, exp_drop); end
    checks++;
    if (bus.boot_err !== 1'b0) begin errors++; $display("FAIL %s boot_err got %b want 0", nm, bus.boot_err); end
  endtask

  task automatic test_empty_err();
    string nm = "empty_err";
    do_reset();
    s_q = '{8'h01, 8'h00, 8'h00, 8'h7E, 8'hFF};
    drive(1, 8);
    model_run();
    checks++;
    if (act_wr.size() != 0) begin errors++; $display("FAIL %s count got %0d want 0", nm, act_wr.size()); end
    checks++;
    if (bus.boot_err !== 1'b1) begin errors++; $display("FAIL %s boot_err got %b want 1", nm, bus.boot_err); end
    checks++;
    if (act_drop != exp_drop || bus.bootloading !== 1'b0) begin
      errors++; $display("FAIL %s boot_drop got %0d/%b want %0d/0", nm, act_drop, bus.bootloading, exp_drop);
    end
  endtask

  task automatic test_stream(input string nm, input int iters, input int max_gap);
    for (int it = 0; it < iters; it++) begin
      do_reset();
      gen_stream(20);
      drive(max_gap, 8);
      model_run();
      checks++;
      if (act_wr.size() != exp_wr.size()) begin errors++; $display("FAIL %s/%0d count got %0d want %0d", nm, it, act_wr.size(), exp_wr.size()); end
      for (int k = 0; k < exp_wr.size() && k < act_wr.size(); k++) begin
        checks++;
        if (act_wr[k] !== exp_wr[k]) begin errors++; $display("FAIL %s/%0d wr%0d got %h want %h", nm, it, k, act_wr[k], exp_wr[k]); end
      end
      checks++;
      if (bus.boot_err !== exp_err) begin errors++; $display("FAIL %s/%0d boot_err got %b want %b", nm, it, bus.boot_err, exp_err); end
      checks++;
      if (act_drop != exp_drop) begin errors++; $display("FAIL %s/%0d boot_drop got %0d want %0d", nm, it, act_drop, exp_drop); end
      if (exp_wr.size() > 0) begin
        checks++;
        if (bus.wdata_data !== exp_wr[$].data || bus.wdata_addr !== exp_wr[$].addr) begin
          errors++; $display("FAIL %s/%0d hold got %h@%0d want %h@%0d", nm, it, bus.wdata_data, bus.wdata_addr, exp_wr[$].data, exp_wr[$].addr);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    test_stream("back_to_back", 4, 0);
  endtask

  task automatic test_random();
    test_stream("random", 6, 3);
  endtask

  task automatic test_reset_mid_word();
    string nm = "reset_mid";
    do_reset();
    s_q = '{8'h01, 8'h01, 8'h00, 8'hAA, 8'hBB};
    drive(1, 0);
    #2 rst_n = 1'b0;
    #3;
    checks++;
    if (bus.bootloading !== 1'b1 || bus.dst !== 3'b000) begin
      errors++; $display("FAIL %s in_reset boot %b dst %b want 1 000", nm, bus.bootloading, bus.dst);
    end
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (act_wr.size() != 0) begin errors++; $display("FAIL %s partial count got %0d want 0", nm, act_wr.size()); end
    act_wr.delete();
    e_q.delete();
    act_drop = -1;
    s_q = '{8'h01, 8'h01, 8'h00, 8'h0D, 8'hF0, 8'hAD, 8'h0B};
    drive(1, 8);
    model_run();
    checks++;
    if (act_wr.size() != 1) begin errors++; $display("FAIL %s count got %0d want 1", nm, act_wr.size()); end
    else begin
      checks++;
      if (act_wr[0] !== exp_wr[0]) begin errors++; $display("FAIL %s wr0 got %h want %h", nm, act_wr[0], exp_wr[0]); end
    end
  endtask

  initial begin
    bus.rx_rdy = 1'b0;
    bus.rx_data = 8'h00;
    test_reset();
    test_imem_two_words();
    test_dmem_end();
    test_empty_err();
    test_back_to_back();
    test_random();
    test_reset_mid_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
